// File: rtl/hazard_ctrl_if.sv
// Bundle of decoded pipeline fields consumed by hazard_ctrl and the controls it returns.
// master: datapath side driving the *_i fields; slave: the hazard controller.
`default_nettype none

interface hazard_ctrl_if;
  logic       valid_id_i;
  logic [4:0] rs_id_i;
  logic [4:0] rt_id_i;
  logic       use_rs_id_i;
  logic       use_rt_id_i;
  logic       md_start_id_i;
  logic       md_use_id_i;
  logic       valid_ex_i;
  logic       reg_wr_ex_i;
  logic       mem_to_reg_ex_i;
  logic [4:0] dst_ex_i;
  logic [4:0] rs_ex_i;
  logic [4:0] rt_ex_i;
  logic       brn_taken_ex_i;
  logic       jump_ex_i;
  logic       reg_wr_mem_i;
  logic [4:0] dst_mem_i;
  logic       reg_wr_wb_i;
  logic [4:0] dst_wb_i;
  logic       stall_if_o;
  logic       stall_id_o;
  logic       clr_id_o;
  logic       clr_ex_o;
  logic [1:0] fwd_a_ex_o;
  logic [1:0] fwd_b_ex_o;
  logic       md_busy_o;

  modport master (
    output valid_id_i, rs_id_i, rt_id_i, use_rs_id_i, use_rt_id_i,
           md_start_id_i, md_use_id_i, valid_ex_i, reg_wr_ex_i,
           mem_to_reg_ex_i, dst_ex_i, rs_ex_i, rt_ex_i, brn_taken_ex_i,
           jump_ex_i, reg_wr_mem_i, dst_mem_i, reg_wr_wb_i, dst_wb_i,
    input  stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_ex_o,
           fwd_b_ex_o, md_busy_o
  );

  modport slave (
    input  valid_id_i, rs_id_i, rt_id_i, use_rs_id_i, use_rt_id_i,
           md_start_id_i, md_use_id_i, valid_ex_i, reg_wr_ex_i,
           mem_to_reg_ex_i, dst_ex_i, rs_ex_i, rt_ex_i, brn_taken_ex_i,
           jump_ex_i, reg_wr_mem_i, dst_mem_i, reg_wr_wb_i, dst_wb_i,
    output stall_if_o, stall_id_o, clr_id_o, clr_ex_o, fwd_a_ex_o,
           fwd_b_ex_o, md_busy_o
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forwarding control and mul/div busy sequencer for a 5-stage MIPS.
// Option macro HAZARD_FWD_EN enables EX operand forwarding. Revision 1.0.
`default_nettype none

module hazard_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int MD_CNT_W   = 6
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  logic [MD_CNT_W-1:0] r_cnt;
  logic [MD_CNT_W-1:0] w_cnt_nxt;
  state_t              w_state;
  logic                w_busy;
  logic                w_redirect;
  logic                w_rs_ex;
  logic                w_rt_ex;
  logic                w_raw_ex;
  logic                w_raw_mem;
  logic                w_load_use;
  logic                w_md_haz;
  logic                w_hold;
  logic                w_accept;
  logic [1:0]          w_fwd_a;
  logic [1:0]          w_fwd_b;

  // The HI/LO counter is the only state; the FSM state is a view of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign w_state = (r_cnt != '0) ? ST_MD_WAIT : ST_RUN;
  assign w_busy  = (w_state == ST_MD_WAIT);

  assign w_redirect = hz.valid_ex_i & (hz.brn_taken_ex_i | hz.jump_ex_i);

  assign w_rs_ex = hz.valid_id_i & hz.use_rs_id_i & (hz.rs_id_i != 5'd0) &
                   hz.reg_wr_ex_i & (hz.rs_id_i == hz.dst_ex_i);
  assign w_rt_ex = hz.valid_id_i & hz.use_rt_id_i & (hz.rt_id_i != 5'd0) &
                   hz.reg_wr_ex_i & (hz.rt_id_i == hz.dst_ex_i);
  assign w_raw_ex = hz.valid_ex_i & (w_rs_ex | w_rt_ex);

  assign w_raw_mem = hz.valid_id_i & hz.reg_wr_mem_i & (hz.dst_mem_i != 5'd0) &
                     ((hz.use_rs_id_i & (hz.rs_id_i == hz.dst_mem_i)) |
                      (hz.use_rt_id_i & (hz.rt_id_i == hz.dst_mem_i)));

  assign w_load_use = hz.mem_to_reg_ex_i & w_raw_ex;
  assign w_md_haz   = w_busy & hz.valid_id_i & hz.md_use_id_i;

`ifdef HAZARD_FWD_EN
  assign w_hold = w_load_use | w_md_haz;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wr_mem,
    input logic [4:0] d_mem,
    input logic       wr_wb,
    input logic [4:0] d_wb
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (wr_mem && (d_mem == src))    sel = 2'b10;
      else if (wr_wb && (d_wb == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(hz.rs_ex_i, hz.reg_wr_mem_i, hz.dst_mem_i,
                           hz.reg_wr_wb_i, hz.dst_wb_i);
  assign w_fwd_b = fwd_sel(hz.rt_ex_i, hz.reg_wr_mem_i, hz.dst_mem_i,
                           hz.reg_wr_wb_i, hz.dst_wb_i);
`else
  // Without bypass paths every EX/MEM producer must drain first; WB relies on write-before-read.
  assign w_hold  = w_load_use | w_md_haz | w_raw_ex | w_raw_mem;
  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
`endif

  // md_start without md_use is not a real HI/LO op, so it never loads the counter.
  assign w_accept = hz.md_start_id_i & hz.md_use_id_i & hz.valid_id_i &
                    ~w_hold & ~w_redirect;

  always_comb begin
    w_cnt_nxt     = r_cnt;
    hz.stall_if_o = 1'b0;
    hz.stall_id_o = 1'b0;
    hz.clr_id_o   = 1'b0;
    hz.clr_ex_o   = 1'b0;
    hz.fwd_a_ex_o = 2'b00;
    hz.fwd_b_ex_o = 2'b00;
    hz.md_busy_o  = 1'b0;

    if (w_accept)    w_cnt_nxt = MD_CNT_W'(MD_LATENCY);
    else if (w_busy) w_cnt_nxt = r_cnt - MD_CNT_W'(1);

    if (!reset) begin
      hz.md_busy_o  = w_busy;
      hz.fwd_a_ex_o = w_fwd_a;
      hz.fwd_b_ex_o = w_fwd_b;
      if (w_redirect) begin
        hz.clr_id_o = 1'b1;
        hz.clr_ex_o = 1'b1;
      end else if (w_hold) begin
        hz.stall_if_o = 1'b1;
        hz.stall_id_o = 1'b1;
        hz.clr_ex_o   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic vs a reference model.
`default_nettype none

module tb_hazard_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   md_rem   = 0;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MD_LATENCY(LAT), .MD_CNT_W(3)) dut (
    .clk   (clk),
    .reset (rst),
    .hz    (hif)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] observed();
    return {hif.stall_if_o, hif.stall_id_o, hif.clr_id_o, hif.clr_ex_o,
            hif.fwd_a_ex_o, hif.fwd_b_ex_o, hif.md_busy_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Does the ID instruction read architectural register r?
  function automatic bit reads(input logic [4:0] r);
    return hif.valid_id_i && (r != 5'd0) &&
           ((hif.use_rs_id_i && hif.rs_id_i == r) || (hif.use_rt_id_i && hif.rt_id_i == r));
  endfunction

  function automatic logic [1:0] src_sel(input logic [4:0] r);
`ifdef HAZARD_FWD_EN
    if (r == 5'd0) return 2'b00;
    if (hif.reg_wr_mem_i && hif.dst_mem_i == r) return 2'b10;
    if (hif.reg_wr_wb_i && hif.dst_wb_i == r) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    hif.valid_id_i = 0; hif.rs_id_i = 0; hif.rt_id_i = 0;
    hif.use_rs_id_i = 0; hif.use_rt_id_i = 0;
    hif.md_start_id_i = 0; hif.md_use_id_i = 0;
    hif.valid_ex_i = 0; hif.reg_wr_ex_i = 0; hif.mem_to_reg_ex_i = 0;
    hif.dst_ex_i = 0; hif.rs_ex_i = 0; hif.rt_ex_i = 0;
    hif.brn_taken_ex_i = 0; hif.jump_ex_i = 0;
    hif.reg_wr_mem_i = 0; hif.dst_mem_i = 0;
    hif.reg_wr_wb_i = 0; hif.dst_wb_i = 0;
  endtask

  // One clock: inputs already applied at posedge+1; check at the falling edge; advance model.
  task automatic cycle(input string tag);
    bit redirect, dep_ex, dep_mem, hold, stall, accept;
    logic [8:0] exp;
    redirect = hif.valid_ex_i && (hif.brn_taken_ex_i || hif.jump_ex_i);
    dep_ex   = hif.valid_ex_i && hif.reg_wr_ex_i && reads(hif.dst_ex_i);
    dep_mem  = hif.reg_wr_mem_i && reads(hif.dst_mem_i);
    hold     = (dep_ex && hif.mem_to_reg_ex_i) ||
               (md_rem > 0 && hif.valid_id_i && hif.md_use_id_i);
`ifndef HAZARD_FWD_EN
    hold = hold || dep_ex || dep_mem;
`endif
    stall  = hold && !redirect;
    accept = hif.md_start_id_i && hif.md_use_id_i && hif.valid_id_i && !hold && !redirect;
    exp = {stall, stall, redirect, stall || redirect,
           src_sel(hif.rs_ex_i), src_sel(hif.rt_ex_i), md_rem > 0};
    if (rst) exp = '0;
    #4;
    chk(tag, observed(), exp);
    if (rst)             md_rem = 0;
    else if (accept)     md_rem = LAT;
    else if (md_rem > 0) md_rem = md_rem - 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_stall;
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    cycle("reset_state");
    rst = 0;

    // Load-use on rs, then the load moves to MEM.
    hif.valid_ex_i = 1; hif.reg_wr_ex_i = 1; hif.mem_to_reg_ex_i = 1; hif.dst_ex_i = 2;
    hif.valid_id_i = 1; hif.rs_id_i = 2; hif.use_rs_id_i = 1;
    cycle("load_use");
    clear_inputs();
    hif.reg_wr_mem_i = 1; hif.dst_mem_i = 2;
    hif.valid_id_i = 1; hif.rs_id_i = 2; hif.use_rs_id_i = 1;
    cycle("load_use_next");

    // Forwarding priority and register zero.
    clear_inputs();
    hif.rs_ex_i = 3; hif.rt_ex_i = 3;
    hif.reg_wr_mem_i = 1; hif.dst_mem_i = 3; hif.reg_wr_wb_i = 1; hif.dst_wb_i = 3;
    cycle("fwd_mem_prio");
    hif.reg_wr_mem_i = 0;
    cycle("fwd_wb");
    hif.rs_ex_i = 0; hif.reg_wr_wb_i = 1; hif.dst_wb_i = 0;
    cycle("fwd_reg0");

    // Redirect overrides a load-use stall.
    clear_inputs();
    hif.valid_ex_i = 1; hif.reg_wr_ex_i = 1; hif.mem_to_reg_ex_i = 1; hif.dst_ex_i = 7;
    hif.brn_taken_ex_i = 1;
    hif.valid_id_i = 1; hif.rt_id_i = 7; hif.use_rt_id_i = 1;
    cycle("redirect_over_stall");
    hif.brn_taken_ex_i = 0; hif.jump_ex_i = 1; hif.mem_to_reg_ex_i = 0;
    cycle("jump_redirect");

    // No-forward RAW against MEM.
    clear_inputs();
    hif.reg_wr_mem_i = 1; hif.dst_mem_i = 5;
    hif.valid_id_i = 1; hif.rs_id_i = 5; hif.use_rs_id_i = 1;
    cycle("raw_mem");

    // mult accepted, mflo waits exactly LAT cycles.
    clear_inputs();
    hif.valid_id_i = 1; hif.md_start_id_i = 1; hif.md_use_id_i = 1;
    cycle("md_accept");
    hif.md_start_id_i = 0;
    n_stall = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      #4;
      if (hif.stall_id_o) n_stall++;
      #(-4 + 4);
      cycle("md_wait");
      if (n_stall != i + 1) break;
    end
    chk("md_stall_count", n_stall, LAT);

    // Reset asserted while the counter holds 2.
    clear_inputs();
    hif.valid_id_i = 1; hif.md_start_id_i = 1; hif.md_use_id_i = 1;
    cycle("md_accept2");
    hif.md_start_id_i = 0; hif.md_use_id_i = 0;
    cycle("md_cnt4");
    cycle("md_cnt3");
    hif.valid_ex_i = 1; hif.jump_ex_i = 1; hif.md_use_id_i = 1;
    hif.reg_wr_mem_i = 1; hif.dst_mem_i = 1; hif.rs_ex_i = 1;
    #1;
    rst = 1;
    #1;
    chk("rst_async", observed(), 9'd0);
    md_rem = 0;
    @(posedge clk); #1;
    cycle("rst_hold");
    rst = 0;
    clear_inputs();
    hif.valid_id_i = 1; hif.md_use_id_i = 1;
    cycle("after_rst");

    // Random traffic with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      hif.valid_id_i      = ($urandom_range(0, 7) != 0);
      hif.rs_id_i         = 5'($urandom_range(0, 3));
      hif.rt_id_i         = 5'($urandom_range(0, 3));
      hif.use_rs_id_i     = 1'($urandom);
      hif.use_rt_id_i     = 1'($urandom);
      hif.md_start_id_i   = ($urandom_range(0, 5) == 0);
      hif.md_use_id_i     = hif.md_start_id_i | ($urandom_range(0, 3) == 0);
      hif.valid_ex_i      = 1'($urandom);
      hif.reg_wr_ex_i     = 1'($urandom);
      hif.mem_to_reg_ex_i = 1'($urandom);
      hif.dst_ex_i        = 5'($urandom_range(0, 3));
      hif.rs_ex_i         = 5'($urandom_range(0, 3));
      hif.rt_ex_i         = 5'($urandom_range(0, 3));
      hif.brn_taken_ex_i  = ($urandom_range(0, 9) == 0);
      hif.jump_ex_i       = ($urandom_range(0, 15) == 0);
      hif.reg_wr_mem_i    = 1'($urandom);
      hif.dst_mem_i       = 5'($urandom_range(0, 3));
      hif.reg_wr_wb_i     = 1'($urandom);
      hif.dst_wb_i        = 5'($urandom_range(0, 3));
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end
endmodule

`default_nettype wire
